snitch_tcdm_bank: RTL and testbench



---
 rtl/snitch_tcdm_bank_pkg.sv | 36 +++
 rtl/snitch_tcdm_bank_alu.sv | 13 +
 rtl/snitch_tcdm_bank.sv | 190 +++++++++++++++++++
 tb/tb_snitch_tcdm_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/snitch_tcdm_bank_pkg.sv
// Shared types for the TCDM bank: FSM states, AMO opcodes and the 32-bit AMO function.
package snitch_tcdm_bank_pkg;

  typedef enum logic {IDLE, AMO_WB} fsm_e;

  // Same encoding as reqrsp_pkg::amo_op_e
  localparam logic [3:0] AMO_NONE = 4'd0;
  localparam logic [3:0] AMO_SWAP = 4'd1;
  localparam logic [3:0] AMO_ADD  = 4'd2;
  localparam logic [3:0] AMO_AND  = 4'd3;
  localparam logic [3:0] AMO_OR   = 4'd4;
  localparam logic [3:0] AMO_XOR  = 4'd5;
  localparam logic [3:0] AMO_MAX  = 4'd6;
  localparam logic [3:0] AMO_MAXU = 4'd7;
  localparam logic [3:0] AMO_MIN  = 4'd8;
  localparam logic [3:0] AMO_MINU = 4'd9;
  localparam logic [3:0] AMO_LR   = 4'd10;
  localparam logic [3:0] AMO_SC   = 4'd11;

  function automatic logic [31:0] amo_compute(input logic [3:0] op, input logic [31:0] old,
                                              input logic [31:0] opd);
    case (op)
      AMO_SWAP: return opd;
      AMO_ADD:  return old + opd;
      AMO_AND:  return old & opd;
      AMO_OR:   return old | opd;
      AMO_XOR:  return old ^ opd;
      AMO_MAX:  return ($signed(old) > $signed(opd)) ? old : opd;
      AMO_MAXU: return (old > opd) ? old : opd;
      AMO_MIN:  return ($signed(old) < $signed(opd)) ? old : opd;
      AMO_MINU: return (old < opd) ? old : opd;
      default:  return old;
    endcase
  endfunction

endpackage

// File: rtl/snitch_tcdm_bank_alu.sv
// Combinational 32-bit AMO ALU for the TCDM bank writeback.
module snitch_tcdm_bank_alu
  import snitch_tcdm_bank_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] old,
  input  logic [31:0] operand,
  output logic [31:0] result
);

  assign result = amo_compute(op, old, operand);

endmodule

// File: rtl/snitch_tcdm_bank.sv
// One TCDM bank: word storage, strobed writes, two-cycle AMOs, fixed-latency responses.
// Define SNITCH_TCDM_BANK_LRSC_EN to add a single LR/SC reservation.
module snitch_tcdm_bank
  import snitch_tcdm_bank_pkg::*;
#(
  parameter int NumWords   = 512,
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 64,
  parameter int UserWidth  = 1,
  parameter int RspLatency = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   q_valid_i,
  output logic                   q_ready_o,
  input  logic [AddrWidth-1:0]   q_addr_i,
  input  logic                   q_write_i,
  input  logic [3:0]             q_amo_i,
  input  logic [DataWidth-1:0]   q_data_i,
  input  logic [DataWidth/8-1:0] q_strb_i,
  input  logic [UserWidth-1:0]   q_user_i,
  output logic [DataWidth-1:0]   p_data_o,
  output logic                   p_valid_o
);

  localparam int IdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int StrbW = DataWidth / 8;
  localparam bit Wide  = (DataWidth == 64);

  if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_dw
    $error("snitch_tcdm_bank: DataWidth must be 32 or 64");
  end
  if (RspLatency < 1) begin : g_bad_lat
    $error("snitch_tcdm_bank: RspLatency must be >= 1");
  end

  logic [DataWidth-1:0] mem [NumWords];

  fsm_e                 state;
  logic                 ready_q;
  logic [IdxW-1:0]      amo_idx;
  logic [3:0]           amo_op;
  logic                 amo_hi;
  logic [31:0]          amo_opd;

  logic [IdxW-1:0]      q_idx;
  logic                 accept, is_amo, is_sc, is_lr, is_wr, sc_ok, q_hi;
  logic [DataWidth-1:0] rdata, rsp_d, wb_old, wb_word;
  logic [31:0]          wb_old32, wb_res, q_opd;

  logic                 wr_en;
  logic [IdxW-1:0]      wr_idx;
  logic [DataWidth-1:0] wr_data;
  logic [StrbW-1:0]     wr_strb;

  logic [RspLatency-1:0]                vld_pipe;
  logic [RspLatency-1:0][DataWidth-1:0] dat_pipe;

  logic unused;
  assign unused = ^{q_addr_i[AddrWidth-1:IdxW], q_user_i};

  assign q_ready_o = ready_q;
  assign q_idx     = q_addr_i[IdxW-1:0];
  assign accept    = q_valid_i & ready_q & ~rst_i;
  assign is_amo    = (q_amo_i >= AMO_SWAP) && (q_amo_i <= AMO_MINU);
  assign is_sc     = (q_amo_i == AMO_SC);
  assign is_lr     = (q_amo_i == AMO_LR);
  assign is_wr     = (q_amo_i == AMO_NONE) && q_write_i;
  assign rdata     = mem[q_idx];

  // The 64-bit AMO lane is chosen by strb[4]; a 32-bit bank always uses the full word
  assign q_hi  = Wide & q_strb_i[StrbW/2];
  assign q_opd = q_hi ? q_data_i[DataWidth-1 -: 32] : q_data_i[31:0];

  assign wb_old   = mem[amo_idx];
  assign wb_old32 = amo_hi ? wb_old[DataWidth-1 -: 32] : wb_old[31:0];

  snitch_tcdm_bank_alu i_alu (
    .op      (amo_op),
    .old     (wb_old32),
    .operand (amo_opd),
    .result  (wb_res)
  );

  always_comb begin
    wb_word = wb_old;
    if (amo_hi) wb_word[DataWidth-1 -: 32] = wb_res;
    else        wb_word[31:0] = wb_res;
  end

`ifdef SNITCH_TCDM_BANK_LRSC_EN
  logic                 res_vld;
  logic [IdxW-1:0]      res_idx;
  logic [UserWidth-1:0] res_user;

  assign sc_ok = res_vld && (res_idx == q_idx) && (res_user == q_user_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_vld  <= 1'b0;
      res_idx  <= '0;
      res_user <= '0;
    end else if (accept) begin
      if (is_lr) begin
        res_vld  <= 1'b1;
        res_idx  <= q_idx;
        res_user <= q_user_i;
      end else if (is_sc) begin
        res_vld <= 1'b0;
      end else if ((is_wr || is_amo) && (q_idx == res_idx)) begin
        res_vld <= 1'b0;
      end
    end
  end
`else
  // Without reservations SC is a plain strobed write that always reports success
  assign sc_ok = 1'b1;
`endif

  // AMO_WB blocks acceptance, so the writeback never collides with a request write
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = q_idx;
    wr_data = q_data_i;
    wr_strb = q_strb_i;
    if (state == AMO_WB) begin
      wr_en   = 1'b1;
      wr_idx  = amo_idx;
      wr_data = wb_word;
      wr_strb = '1;
    end else if (accept && (is_wr || (is_sc && sc_ok))) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      amo_idx <= '0;
      amo_op  <= AMO_NONE;
      amo_hi  <= 1'b0;
      amo_opd <= '0;
    end else begin
      case (state)
        IDLE: if (accept && is_amo) begin
          state   <= AMO_WB;
          ready_q <= 1'b0;
          amo_idx <= q_idx;
          amo_op  <= q_amo_i;
          amo_hi  <= q_hi;
          amo_opd <= q_opd;
        end
        AMO_WB: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_d = is_sc ? {{(DataWidth-1){1'b0}}, ~sc_ok} : rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      if (accept) dat_pipe[0] <= rsp_d;
      for (int i = 1; i < RspLatency; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign p_valid_o = vld_pipe[RspLatency-1];
  assign p_data_o  = dat_pipe[RspLatency-1];

endmodule

// File: tb/tb_snitch_tcdm_bank.sv
// Directed bench: a latency-1 bank for function, a latency-3 bank for pipeline and reset.
module tb_snitch_tcdm_bank;

  logic        clk = 1'b0;
  logic        rst, rst3;
  logic        q_valid;
  logic [31:0] q_addr;
  logic        q_write;
  logic [3:0]  q_amo;
  logic [63:0] q_data;
  logic [7:0]  q_strb;
  logic [0:0]  q_user;
  logic        q_ready, p_valid, q_ready3, p_valid3;
  logic [63:0] p_data, p_data3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snitch_tcdm_bank #(.RspLatency(1)) dut (
    .clk_i(clk), .rst_i(rst), .q_valid_i(q_valid), .q_ready_o(q_ready),
    .q_addr_i(q_addr), .q_write_i(q_write), .q_amo_i(q_amo), .q_data_i(q_data),
    .q_strb_i(q_strb), .q_user_i(q_user), .p_data_o(p_data), .p_valid_o(p_valid)
  );

  snitch_tcdm_bank #(.RspLatency(3)) dut3 (
    .clk_i(clk), .rst_i(rst3), .q_valid_i(q_valid), .q_ready_o(q_ready3),
    .q_addr_i(q_addr), .q_write_i(q_write), .q_amo_i(q_amo), .q_data_i(q_data),
    .q_strb_i(q_strb), .q_user_i(q_user), .p_data_o(p_data3), .p_valid_o(p_valid3)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One request, driven on a falling edge; response sampled on the next falling edge
  task automatic req(input logic [31:0] a, input logic w, input logic [3:0] amo,
                     input logic [63:0] d, input logic [7:0] s, input logic u,
                     output logic [63:0] rd, output logic rv, output logic rdy);
    @(negedge clk);
    chk("ready_before_req", q_ready, 1'b1);
    q_valid = 1'b1; q_addr = a; q_write = w; q_amo = amo; q_data = d; q_strb = s; q_user = u;
    @(posedge clk);
    @(negedge clk);
    q_valid = 1'b0;
    rd = p_data; rv = p_valid; rdy = q_ready;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [63:0] exp);
    logic [63:0] rd;
    logic rv, rdy;
    req(a, 1'b0, 4'd0, 64'h0, 8'h00, 1'b0, rd, rv, rdy);
    chk({tag, "_valid"}, rv, 1'b1);
    chk(tag, rd, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                    input logic u);
    logic [63:0] rd;
    logic rv, rdy;
    req(a, 1'b1, 4'd0, d, s, u, rd, rv, rdy);
  endtask

  task automatic amo_chk(input string tag, input logic [31:0] a, input logic [3:0] op,
                         input logic [63:0] d, input logic [7:0] s, input logic [63:0] old);
    logic [63:0] rd;
    logic rv, rdy;
    req(a, 1'b0, op, d, s, 1'b0, rd, rv, rdy);
    chk({tag, "_ready_low"}, rdy, 1'b0);
    chk({tag, "_old"}, rd, old);
  endtask

  initial begin
    logic [63:0] rd;
    logic rv, rdy;
    rst = 1'b1; rst3 = 1'b1;
    q_valid = 1'b0; q_addr = '0; q_write = 1'b0; q_amo = '0; q_data = '0; q_strb = '0;
    q_user = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", q_ready, 1'b1);
    chk("rst_valid", p_valid, 1'b0);
    chk("rst_data", p_data, 64'h0);
    chk("rst_ready3", q_ready3, 1'b1);
    chk("rst_valid3", p_valid3, 1'b0);
    rst = 1'b0; rst3 = 1'b0;

    // Full and partial strobed writes, address wrap
    wr(5, 64'h1122334455667788, 8'hFF, 1'b0);
    rd_chk("rd_full", 5, 64'h1122334455667788);
    req(5, 1'b1, 4'd0, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, rd, rv, rdy);
    chk("wr_prewrite", rd, 64'h1122334455667788);
    rd_chk("rd_strb", 5, 64'h11223344AAAAAAAA);
    rd_chk("rd_wrap", 5 + 512, 64'h11223344AAAAAAAA);

    // AMO add wraps in the low lane; upper lane xor leaves the low lane alone
    wr(7, 64'h00000000FFFFFFF0, 8'hFF, 1'b0);
    amo_chk("add", 7, 4'd2, 64'h20, 8'h0F, 64'h00000000FFFFFFF0);
    rd_chk("rd_add", 7, 64'h0000000000000010);
    amo_chk("xor_hi", 7, 4'd5, 64'hFFFF000000000000, 8'hF0, 64'h0000000000000010);
    rd_chk("rd_xor_hi", 7, 64'hFFFF000000000010);

    // Signed vs unsigned compare; read held valid through the stall sees the writeback
    wr(3, 64'h0000000080000000, 8'hFF, 1'b0);
    @(negedge clk);
    q_valid = 1'b1; q_addr = 3; q_write = 1'b0; q_amo = 4'd6; q_data = 64'h1; q_strb = 8'h0F;
    @(negedge clk);
    q_amo = 4'd0;
    chk("max_ready_low", q_ready, 1'b0);
    chk("max_old", p_data, 64'h0000000080000000);
    @(negedge clk);
    chk("stall_no_rsp", p_valid, 1'b0);
    chk("stall_ready_back", q_ready, 1'b1);
    @(negedge clk);
    q_valid = 1'b0;
    chk("b2b_valid", p_valid, 1'b1);
    chk("b2b_max", p_data, 64'h0000000000000001);
    wr(3, 64'h0000000080000000, 8'hFF, 1'b0);
    amo_chk("maxu", 3, 4'd7, 64'h1, 8'h0F, 64'h0000000080000000);
    rd_chk("rd_maxu", 3, 64'h0000000080000000);
    amo_chk("min", 3, 4'd8, 64'h1, 8'h0F, 64'h0000000080000000);
    rd_chk("rd_min", 3, 64'h0000000080000000);
    amo_chk("minu", 3, 4'd9, 64'h1, 8'h0F, 64'h0000000080000000);
    rd_chk("rd_minu", 3, 64'h0000000000000001);
    amo_chk("swap", 3, 4'd1, 64'hDEADBEEF, 8'h0F, 64'h0000000000000001);
    rd_chk("rd_swap", 3, 64'h00000000DEADBEEF);

`ifdef SNITCH_TCDM_BANK_LRSC_EN
    wr(9, 64'h0, 8'hFF, 1'b0);
    req(9, 1'b0, 4'd10, 64'h0, 8'h00, 1'b0, rd, rv, rdy);
    chk("lr1", rd, 64'h0);
    wr(9, 64'h55, 8'hFF, 1'b1);
    req(9, 1'b1, 4'd11, 64'h77, 8'hFF, 1'b0, rd, rv, rdy);
    chk("sc_broken", rd, 64'h1);
    rd_chk("rd_sc_broken", 9, 64'h55);
    req(9, 1'b0, 4'd10, 64'h0, 8'h00, 1'b0, rd, rv, rdy);
    chk("lr2", rd, 64'h55);
    req(9, 1'b1, 4'd11, 64'h77, 8'hFF, 1'b0, rd, rv, rdy);
    chk("sc_ok", rd, 64'h0);
    rd_chk("rd_sc_ok", 9, 64'h77);
    req(9, 1'b1, 4'd11, 64'h99, 8'hFF, 1'b0, rd, rv, rdy);
    chk("sc_cleared", rd, 64'h1);
    rd_chk("rd_sc_cleared", 9, 64'h77);
`else
    wr(9, 64'h0, 8'hFF, 1'b0);
    req(9, 1'b1, 4'd11, 64'h77, 8'hFF, 1'b0, rd, rv, rdy);
    chk("sc_plain", rd, 64'h0);
    req(9, 1'b0, 4'd10, 64'h0, 8'h00, 1'b0, rd, rv, rdy);
    chk("lr_plain", rd, 64'h77);
`endif

    // Latency 3: four back-to-back reads come out in order three cycles later
    for (int k = 0; k < 4; k++) wr(20 + k, {32'hC0DE0000 + k, 32'h0}, 8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("lat3_valid_%0d", k), p_valid3, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6)
        chk($sformatf("lat3_data_%0d", k), p_data3, {32'hC0DE0000 + (k - 3), 32'h0});
      if (k < 4) begin
        q_valid = 1'b1; q_addr = 20 + k; q_write = 1'b0; q_amo = 4'd0;
      end else q_valid = 1'b0;
    end

    // Reset with responses in flight drops them all
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) chk("pre_rst_valid3", p_valid3, 1'b1);
      q_valid = 1'b1; q_addr = 20 + k;
    end
    @(negedge clk);
    chk("pre_rst_data3", p_data3, {32'hC0DE0001, 32'h0});
    q_valid = 1'b0; rst3 = 1'b1;
    #1;
    chk("rst_mid_valid3", p_valid3, 1'b0);
    chk("rst_mid_ready3", q_ready3, 1'b1);
    @(negedge clk);
    rst3 = 1'b0;
    chk("rst_drop_valid3_a", p_valid3, 1'b0);
    @(negedge clk);
    chk("rst_drop_valid3_b", p_valid3, 1'b0);
    chk("rst_after_ready3", q_ready3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
